// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: controller states, opcodes, datapath select encodings and the
// packed control-output vector driven by the multicycle controller.
package mips_pkg;

  typedef enum logic [3:0] {
    StReset,
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StRtypeEx,
    StRtypeWb,
    StItypeEx,
    StItypeWb,
    StBranch,
    StJump
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  localparam int unsigned CtrlWidth = $bits(ctrl_t);

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_XORI);
  endfunction

  // Logical immediates zero-extend; arithmetic ones sign-extend.
  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_J) || is_itype(op);
  endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational output decode for the multicycle controller: state, opcode, zero and mem_ready
// map to the full datapath control vector.
module mc_ctrl_outputs
  import mips_pkg::*;
(
  input  logic [3:0]           state_i,
  input  logic [5:0]           opcode_i,
  input  logic                 zero_i,
  input  logic                 mem_ready_i,
  output logic [CtrlWidth-1:0] ctrl_o
);

  state_e state;
  ctrl_t  ctrl;

  assign state = state_e'(state_i);

  always_comb begin
    ctrl = '0;
    case (state)
      StFetch: begin
        ctrl.mem_req   = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        // IR and PC+4 commit only on the cycle memory completes the fetch.
        ctrl.ir_write  = mem_ready_i;
        ctrl.pc_write  = mem_ready_i;
      end
      StDecode: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUSRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.illegal   = !is_legal(opcode_i);
      end
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ext_zero  = 1'b0;
      end
      StMemRd: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      StMemWr: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      StRtypeEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      StRtypeWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      StItypeEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ITYPE;
        ctrl.ext_zero  = is_logic_imm(opcode_i);
      end
      StItypeWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      StBranch: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_write  = (opcode_i == OP_BEQ) ? zero_i : !zero_i;
      end
      StJump: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign ctrl_o = ctrl;

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main control FSM: state register and next-state logic; output decode lives in
// mc_ctrl_outputs.
module mips_mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       ext_zero_o,
  output logic [1:0] alu_op_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       illegal_o
);

  state_e                 state_q, state_d;
  logic [CtrlWidth-1:0]   ctrl_vec;
  ctrl_t                  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset:   state_d = StFetch;
      StFetch:   state_d = mem_ready_i ? StDecode : StFetch;
      StDecode: begin
        if ((opcode_i == OP_LW) || (opcode_i == OP_SW)) begin
          state_d = StMemAdr;
        end else if (opcode_i == OP_RTYPE) begin
          state_d = StRtypeEx;
        end else if (is_itype(opcode_i)) begin
          state_d = StItypeEx;
        end else if ((opcode_i == OP_BEQ) || (opcode_i == OP_BNE)) begin
          state_d = StBranch;
        end else if (opcode_i == OP_J) begin
          state_d = StJump;
        end else begin
          state_d = StFetch;
        end
      end
      StMemAdr:  state_d = (opcode_i == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   state_d = mem_ready_i ? StMemWb : StMemRd;
      StMemWb:   state_d = StFetch;
      StMemWr:   state_d = mem_ready_i ? StFetch : StMemWr;
      StRtypeEx: state_d = StRtypeWb;
      StRtypeWb: state_d = StFetch;
      StItypeEx: state_d = StItypeWb;
      StItypeWb: state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
      default:   state_d = StReset;
    endcase
  end

  mc_ctrl_outputs u_outputs (
    .state_i     (state_q),
    .opcode_i    (opcode_i),
    .zero_i      (zero_i),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (ctrl_vec)
  );

  assign ctrl = ctrl_t'(ctrl_vec);

  always_comb begin
    mem_req_o    = ctrl.mem_req;
    mem_write_o  = ctrl.mem_write;
    iord_o       = ctrl.iord;
    ir_write_o   = ctrl.ir_write;
    pc_write_o   = ctrl.pc_write;
    pc_src_o     = ctrl.pc_src;
    alu_src_a_o  = ctrl.alu_src_a;
    alu_src_b_o  = ctrl.alu_src_b;
    ext_zero_o   = ctrl.ext_zero;
    alu_op_o     = ctrl.alu_op;
    reg_dst_o    = ctrl.reg_dst;
    mem_to_reg_o = ctrl.mem_to_reg;
    reg_write_o  = ctrl.reg_write;
    illegal_o    = ctrl.illegal;
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: each cycle's expected control vector is pushed to a
// scoreboard when inputs are driven and popped against the DUT on the falling edge.
module tb_mips_mc_controller;

  typedef enum {
    SReset, SFetch, SDecode, SMemAdr, SMemRd, SMemWb, SMemWr,
    SRtypeEx, SRtypeWb, SItypeEx, SItypeWb, SBranch, SJump
  } tst_e;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] XORI = 6'b001110;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic       alu_src_a, ext_zero, reg_dst, mem_to_reg, reg_write, illegal;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [16:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  mips_mc_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode_i     (opcode),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .mem_req_o    (mem_req),
    .mem_write_o  (mem_write),
    .iord_o       (iord),
    .ir_write_o   (ir_write),
    .pc_write_o   (pc_write),
    .pc_src_o     (pc_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .ext_zero_o   (ext_zero),
    .alu_op_o     (alu_op),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .illegal_o    (illegal)
  );

  // Vector layout: req wr iord irw pcw pc_src[2] a b[2] ez aop[2] rd m2r rw ill
  function automatic logic [16:0] exp_out(tst_e st, logic [5:0] op, logic z, logic rdy);
    logic       req, wr, io, irw, pcw, a, ez, rd, m2r, rw, ill;
    logic [1:0] ps, b, aop;
    {req, wr, io, irw, pcw, a, ez, rd, m2r, rw, ill} = '0;
    {ps, b, aop} = '0;
    case (st)
      SFetch:   begin req = 1; b = 2'b01; irw = rdy; pcw = rdy; end
      SDecode:  begin
        b = 2'b11;
        ill = !(op inside {LW, SW, RTY, ADDI, SLTI, ANDI, ORI, XORI, BEQ, BNE, JMP});
      end
      SMemAdr:  begin a = 1; b = 2'b10; end
      SMemRd:   begin req = 1; io = 1; end
      SMemWb:   begin rw = 1; m2r = 1; end
      SMemWr:   begin req = 1; wr = 1; io = 1; end
      SRtypeEx: begin a = 1; aop = 2'b10; end
      SRtypeWb: begin rw = 1; rd = 1; end
      SItypeEx: begin a = 1; b = 2'b10; aop = 2'b11; ez = op inside {ANDI, ORI, XORI}; end
      SItypeWb: begin rw = 1; end
      SBranch:  begin a = 1; aop = 2'b01; ps = 2'b01; pcw = (op == BEQ) ? z : !z; end
      SJump:    begin ps = 2'b10; pcw = 1; end
      default:  ;
    endcase
    return {req, wr, io, irw, pcw, ps, a, b, ez, aop, rd, m2r, rw, ill};
  endfunction

  task automatic drive(tst_e st, logic [5:0] op, logic z, logic rdy);
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    exp_q.push_back(exp_out(st, op, z, rdy));
    tag_q.push_back(st.name());
  endtask

  task automatic check_now();
    logic [16:0] obs, exp;
    string       tag;
    obs = {mem_req, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           ext_zero, alu_op, reg_dst, mem_to_reg, reg_write, illegal};
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL vec%0d %s: observed %b expected %b", n_vec, tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic cyc(tst_e st, logic [5:0] op, logic z, logic rdy);
    drive(st, op, z, rdy);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = LW; zero = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc(SReset, LW, 1, 1);
    rst_n = 1'b1;
    cyc(SReset, LW, 1, 1);

    // lw with two wait cycles in MEMRD
    cyc(SFetch, LW, 0, 1);  cyc(SDecode, LW, 0, 0); cyc(SMemAdr, LW, 0, 1);
    cyc(SMemRd, LW, 0, 0);  cyc(SMemRd, LW, 0, 0);  cyc(SMemRd, LW, 0, 1);
    cyc(SMemWb, LW, 0, 0);
    // sw with one fetch wait
    cyc(SFetch, SW, 0, 0);  cyc(SFetch, SW, 0, 1);  cyc(SDecode, SW, 0, 1);
    cyc(SMemAdr, SW, 0, 0); cyc(SMemWr, SW, 0, 1);
    // R-type and I-types
    cyc(SFetch, RTY, 0, 1); cyc(SDecode, RTY, 0, 1); cyc(SRtypeEx, RTY, 1, 0);
    cyc(SRtypeWb, RTY, 0, 1);
    cyc(SFetch, ORI, 0, 1); cyc(SDecode, ORI, 0, 1); cyc(SItypeEx, ORI, 0, 1);
    cyc(SItypeWb, ORI, 0, 1);
    cyc(SFetch, SLTI, 0, 1); cyc(SDecode, SLTI, 0, 1); cyc(SItypeEx, SLTI, 0, 1);
    cyc(SItypeWb, SLTI, 0, 1);
    cyc(SFetch, ADDI, 0, 1); cyc(SDecode, ADDI, 0, 1); cyc(SItypeEx, ADDI, 0, 1);
    cyc(SItypeWb, ADDI, 0, 1);
    cyc(SFetch, XORI, 0, 1); cyc(SDecode, XORI, 0, 1); cyc(SItypeEx, XORI, 0, 1);
    cyc(SItypeWb, XORI, 0, 1);
    // branches, taken and not taken
    cyc(SFetch, BEQ, 0, 1); cyc(SDecode, BEQ, 0, 1); cyc(SBranch, BEQ, 1, 1);
    cyc(SFetch, BEQ, 0, 1); cyc(SDecode, BEQ, 0, 1); cyc(SBranch, BEQ, 0, 1);
    cyc(SFetch, BNE, 0, 1); cyc(SDecode, BNE, 0, 1); cyc(SBranch, BNE, 0, 1);
    cyc(SFetch, BNE, 0, 1); cyc(SDecode, BNE, 1, 1); cyc(SBranch, BNE, 1, 1);
    // jump, then illegal opcode
    cyc(SFetch, JMP, 0, 1); cyc(SDecode, JMP, 0, 1); cyc(SJump, JMP, 0, 0);
    cyc(SFetch, BAD, 0, 1); cyc(SDecode, BAD, 0, 1);
    // reset dropped mid-cycle while MEMWR waits
    cyc(SFetch, SW, 0, 1);  cyc(SDecode, SW, 0, 1); cyc(SMemAdr, SW, 0, 1);
    cyc(SMemWr, SW, 0, 0);
    drive(SMemWr, SW, 0, 0);
    @(negedge clk);
    check_now();
    #2;
    rst_n = 1'b0;
    drive(SReset, SW, 1, 1);
    #1;
    check_now();
    @(posedge clk);
    #1;
    cyc(SReset, SW, 1, 1);
    rst_n = 1'b1;
    cyc(SReset, SW, 1, 1);
    cyc(SFetch, JMP, 0, 1); cyc(SDecode, JMP, 0, 1); cyc(SJump, JMP, 0, 1);
    cyc(SFetch, JMP, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
